sdram_rd_arb: RTL and testbench

- Arbitrates SDRAM read access between two requesters: client 0 (CPU ROM fetch) and client 1 (LCD compositor mask/background reads).
- Sits between the requesters and the SDRAM controller read port, sending one byte read at a time.
- Returns the read data and a one-cycle acknowledge to the winning client.
- Drives the LCD compositor's `rdy` enable so the compositor stalls while its read is outstanding.

---
 rtl/sdram_rd_arb.sv | 167 ++++++++++++++++
 tb/tb_sdram_rd_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_arb.sv
// Two-client SDRAM byte-read arbiter: client 0 (CPU ROM) and client 1 (LCD compositor).
// Default build uses fixed priority with client 0 first; define SDRAM_ARB_RR_EN for round-robin.
module sdram_rd_arb #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  output logic              c0_ack,
  output logic [7:0]        c0_data,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  output logic              c1_ack,
  output logic [7:0]        c1_data,
  output logic              c1_rdy,
  output logic              sd_req,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_dout,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                sd_req_q, sd_req_d;
  logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          c0_data_q, c0_data_d;
  logic [7:0]          c1_data_q, c1_data_d;
  logic                c1_rdy_q, c1_rdy_d;
  logic                err_q, err_d;
  logic                any_req;
  logic                pick;
  logic                timed_out;

  assign any_req   = c0_req | c1_req;
  assign timed_out = !sd_ack && (cnt_q == CntLast);

`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the client not granted last wins; last_q resets to 1 so client 0 wins first.
  always_comb begin
    if (c0_req && c1_req) begin
      pick = ~last_q;
    end else begin
      pick = ~c0_req;
    end
    last_d = last_q;
    if (state_q == StIdle && any_req) begin
      last_d = pick;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick = ~c0_req;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: if (sd_ack || timed_out) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state logic
  always_comb begin
    win_d     = win_q;
    sd_req_d  = sd_req_q;
    sd_addr_d = sd_addr_q;
    cnt_d     = cnt_q;
    c0_data_d = c0_data_q;
    c1_data_d = c1_data_q;
    c1_rdy_d  = c1_rdy_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d     = pick;
          sd_addr_d = pick ? c1_addr : c0_addr;
          sd_req_d  = 1'b1;
          cnt_d     = 8'd0;
          c1_rdy_d  = ~pick;
        end
      end
      StIssue: begin
        if (sd_ack || timed_out) begin
          sd_req_d = 1'b0;
          // c1_rdy rises with the ack cycle so the compositor resumes on the returned data.
          c1_rdy_d = 1'b1;
          if (win_q) begin
            c1_data_d = sd_ack ? sd_dout : 8'hFF;
          end else begin
            c0_data_d = sd_ack ? sd_dout : 8'hFF;
          end
          if (!sd_ack) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q     <= 1'b0;
      sd_req_q  <= 1'b0;
      sd_addr_q <= '0;
      cnt_q     <= 8'd0;
      c0_data_q <= 8'd0;
      c1_data_q <= 8'd0;
      c1_rdy_q  <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      win_q     <= win_d;
      sd_req_q  <= sd_req_d;
      sd_addr_q <= sd_addr_d;
      cnt_q     <= cnt_d;
      c0_data_q <= c0_data_d;
      c1_data_q <= c1_data_d;
      c1_rdy_q  <= c1_rdy_d;
      err_q     <= err_d;
    end
  end

  // Output logic
  always_comb begin
    c0_ack  = (state_q == StDone) && !win_q;
    c1_ack  = (state_q == StDone) && win_q;
    c0_data = c0_data_q;
    c1_data = c1_data_q;
    c1_rdy  = c1_rdy_q;
    sd_req  = sd_req_q;
    sd_addr = sd_addr_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_sdram_rd_arb.sv
// Directed bench for sdram_rd_arb: vector table of single-client reads plus hand-written
// sequences for ties, timeout, reset mid-transfer and a one-cycle request pulse.
module tb_sdram_rd_arb;
  localparam int AW = 25;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          c0_req = 1'b0;
  logic [AW-1:0] c0_addr = '0;
  logic          c0_ack;
  logic [7:0]    c0_data;
  logic          c1_req = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic          c1_ack;
  logic [7:0]    c1_data;
  logic          c1_rdy;
  logic          sd_req;
  logic [AW-1:0] sd_addr;
  logic          sd_ack = 1'b0;
  logic [7:0]    sd_dout = 8'h00;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_rd_arb #(.ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c0_req  (c0_req),
    .c0_addr (c0_addr),
    .c0_ack  (c0_ack),
    .c0_data (c0_data),
    .c1_req  (c1_req),
    .c1_addr (c1_addr),
    .c1_ack  (c1_ack),
    .c1_data (c1_data),
    .c1_rdy  (c1_rdy),
    .sd_req  (sd_req),
    .sd_addr (sd_addr),
    .sd_ack  (sd_ack),
    .sd_dout (sd_dout),
    .err     (err)
  );

  typedef struct {
    bit            c0;
    bit            c1;
    logic [AW-1:0] addr;
    logic [7:0]    dout;
    int            k;
    bit            exp_cl;
    logic [AW-1:0] exp_addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where sd_req is seen high.
  task automatic wait_sd_req();
    bit ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sd_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("sd_req_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_c0_ack"}, 32'(c0_ack), 32'd0);
    check({tag, "_c1_ack"}, 32'(c1_ack), 32'd0);
    check({tag, "_c0_data"}, 32'(c0_data), 32'd0);
    check({tag, "_c1_data"}, 32'(c1_data), 32'd0);
    check({tag, "_c1_rdy"}, 32'(c1_rdy), 32'd1);
    check({tag, "_sd_req"}, 32'(sd_req), 32'd0);
    check({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Serve one transfer: sd_ack arrives k cycles after sd_req is first seen.
  task automatic serve(input string tag, input bit cl, input logic [AW-1:0] addr,
                       input logic [7:0] dout, input int k, input bit drop0, input bit drop1);
    wait_sd_req();
    check({tag, "_sd_addr"}, 32'(sd_addr), 32'(addr));
    check({tag, "_rdy_busy"}, 32'(c1_rdy), 32'(!cl));
    check({tag, "_no_early_ack"}, 32'({c0_ack, c1_ack}), 32'd0);
    repeat (k) @(negedge clk);
    sd_ack  = 1'b1;
    sd_dout = dout;
    @(negedge clk);
    sd_ack  = 1'b0;
    check({tag, "_c0_ack"}, 32'(c0_ack), 32'(!cl));
    check({tag, "_c1_ack"}, 32'(c1_ack), 32'(cl));
    check({tag, "_data"}, 32'(cl ? c1_data : c0_data), 32'(dout));
    check({tag, "_sd_req_low"}, 32'(sd_req), 32'd0);
    check({tag, "_rdy_ack"}, 32'(c1_rdy), 32'd1);
    if (drop0) c0_req = 1'b0;
    if (drop1) c1_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'({c0_ack, c1_ack}), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int   cnt;
    int   acks;
    bit   exp_cl;

    vecs[0] = '{c0: 1, c1: 0, addr: 25'h0000100, dout: 8'h5A, k: 3, exp_cl: 0,
                exp_addr: 25'h0000100};
    vecs[1] = '{c0: 0, c1: 1, addr: 25'h004B010, dout: 8'hA5, k: 0, exp_cl: 1,
                exp_addr: 25'h004B010};
    vecs[2] = '{c0: 1, c1: 0, addr: 25'h1FFFFFF, dout: 8'h00, k: 4, exp_cl: 0,
                exp_addr: 25'h1FFFFFF};
    vecs[3] = '{c0: 0, c1: 1, addr: 25'h0000000, dout: 8'h3C, k: 1, exp_cl: 1,
                exp_addr: 25'h0000000};
    vecs[4] = '{c0: 0, c1: 1, addr: 25'h1555555, dout: 8'hC3, k: 2, exp_cl: 1,
                exp_addr: 25'h1555555};

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // sd_ack while idle must not produce an ack
    sd_ack  = 1'b1;
    sd_dout = 8'h77;
    @(negedge clk);
    check("idle_sd_ack_c0", 32'(c0_ack), 32'd0);
    check("idle_sd_ack_c1", 32'(c1_ack), 32'd0);
    check("idle_sd_req", 32'(sd_req), 32'd0);
    sd_ack = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      c0_req = vecs[i].c0;
      c1_req = vecs[i].c1;
      if (vecs[i].c0) c0_addr = vecs[i].addr;
      if (vecs[i].c1) c1_addr = vecs[i].addr;
      @(negedge clk);
      serve($sformatf("vec%0d", i), vecs[i].exp_cl, vecs[i].exp_addr, vecs[i].dout,
            vecs[i].k, 1'b1, 1'b1);
    end

    // Tie, both held for four transfers, then c1 alone
    c0_addr = 25'h10;
    c1_addr = 25'h4B010;
    c0_req  = 1'b1;
    c1_req  = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      exp_cl = RrEn ? bit'(j % 2) : 1'b0;
      serve($sformatf("tie%0d", j), exp_cl, exp_cl ? 25'h4B010 : 25'h10,
            8'(8'h20 + j), 1, (j == 3), 1'b0);
    end
    serve("tie_tail", 1'b1, 25'h4B010, 8'h6E, 0, 1'b0, 1'b1);

    // Timeout: controller never acks
    c1_addr = 25'h0ABCDE;
    c1_req  = 1'b1;
    @(negedge clk);
    wait_sd_req();
    cnt = 0;
    while (sd_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("to_issue_cycles", 32'(cnt), 32'd8);
    check("to_c1_ack", 32'(c1_ack), 32'd1);
    check("to_c0_ack", 32'(c0_ack), 32'd0);
    check("to_c1_data", 32'(c1_data), 32'hFF);
    c1_req = 1'b0;
    @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_ack_once", 32'(c1_ack), 32'd0);
    c0_addr = 25'h00042;
    c0_req  = 1'b1;
    @(negedge clk);
    serve("post_to", 1'b0, 25'h00042, 8'h81, 2, 1'b1, 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    // One-cycle c1 request pulse; address change after grant is ignored
    c1_addr = 25'h0001234;
    c1_req  = 1'b1;
    @(negedge clk);
    c1_req  = 1'b0;
    c1_addr = 25'h1F0F0F0;
    check("pulse_sd_req", 32'(sd_req), 32'd1);
    check("pulse_sd_addr", 32'(sd_addr), 32'h0001234);
    @(negedge clk);
    check("pulse_addr_hold", 32'(sd_addr), 32'h0001234);
    sd_ack  = 1'b1;
    sd_dout = 8'hD2;
    @(negedge clk);
    sd_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (c1_ack) begin
        acks++;
        check("pulse_data", 32'(c1_data), 32'hD2);
      end
      @(negedge clk);
    end
    check("pulse_ack_count", 32'(acks), 32'd1);
    check("pulse_idle_sd_req", 32'(sd_req), 32'd0);

    // Reset asserted while in ISSUE
    c1_addr = 25'h0033333;
    c1_req  = 1'b1;
    @(negedge clk);
    wait_sd_req();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check("rst_hold_ack", 32'({c0_ack, c1_ack}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    serve("post_rst", 1'b1, 25'h0033333, 8'h99, 1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
